// File: rtl/melody_player_if.sv
// Control/output bundle between the user-control logic and the melody sequencer.
// The master drives start/stop and observes the tone outputs; the slave is the player itself.
interface melody_player_if;
  logic        start;
  logic        stop;
  logic [31:0] freq;
  logic [2:0]  note_idx;
  logic        busy;
  logic        done;

  modport master (
    output start, stop,
    input  freq, note_idx, busy, done
  );

  modport slave (
    input  start, stop,
    output freq, note_idx, busy, done
  );
endinterface

// File: rtl/melody_player.sv
// Fixed 8-note tone sequencer feeding a square-wave stage; outputs registered, start/stop act one cycle after sampling.
// No backpressure: stop aborts at once, start is ignored while busy. MELODY_LOOP_EN makes the song repeat forever.
module melody_player #(
  parameter int CLK_FREQ = 50000000,
  parameter int GAP_MS   = 20
) (
  input  logic           clk,
  input  logic           rst,
  melody_player_if.slave bus
);

  localparam int                TICKS_PER_MS = CLK_FREQ / 1000;
  localparam int                TICK_W       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICKS_PER_MS - 1);
  localparam logic [15:0]       GAP_LEN      = 16'(GAP_MS);
  localparam bit                HAS_GAP      = (GAP_MS > 0);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

  typedef struct packed {
    logic [15:0] hz;
    logic [15:0] ms;
  } note_t;

  function automatic note_t note_lookup(input logic [2:0] idx);
    note_t n;
    case (idx)
      3'd0:    n = '{hz: 16'd262, ms: 16'd250};
      3'd1:    n = '{hz: 16'd294, ms: 16'd250};
      3'd2:    n = '{hz: 16'd330, ms: 16'd250};
      3'd3:    n = '{hz: 16'd349, ms: 16'd250};
      3'd4:    n = '{hz: 16'd392, ms: 16'd500};
      3'd5:    n = '{hz: 16'd0,   ms: 16'd250};
      3'd6:    n = '{hz: 16'd392, ms: 16'd250};
      default: n = '{hz: 16'd262, ms: 16'd500};
    endcase
    return n;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        note_q, note_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [15:0]       ms_q, ms_d;
  logic [31:0]       freq_q, freq_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  note_t             cur_note;
  logic [15:0]       period_len;
  logic              period_end;
  state_t            adv_state;
  logic [2:0]        adv_note;
  logic              enter;

  // period_end marks the final cycle of the current PLAY or GAP interval
  always_comb begin
    cur_note   = note_lookup(note_q);
    period_len = (state_q == GAP) ? GAP_LEN : cur_note.ms;
    period_end = (tick_q == TICK_LAST) && (ms_q == period_len - 16'd1);
  end

  always_comb begin
    adv_state = PLAY;
    adv_note  = note_q + 3'd1;
`ifdef MELODY_LOOP_EN
    // 3-bit increment wraps note 7 back to note 0
    adv_state = PLAY;
`else
    if (note_q == 3'd7) begin
      adv_state = DONE;
      adv_note  = note_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    enter   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = PLAY;
          note_d  = 3'd0;
          enter   = 1'b1;
        end
      end
      PLAY: begin
        if (period_end) begin
          enter = 1'b1;
          if (HAS_GAP) begin
            state_d = GAP;
          end else begin
            state_d = adv_state;
            note_d  = adv_note;
          end
        end
      end
      GAP: begin
        if (period_end) begin
          enter   = 1'b1;
          state_d = adv_state;
          note_d  = adv_note;
        end
      end
      DONE: begin
        state_d = IDLE;
        enter   = 1'b1;
      end
      default: begin
        state_d = IDLE;
        enter   = 1'b1;
      end
    endcase

    if (bus.stop) begin
      state_d = IDLE;
      note_d  = note_q;
      enter   = 1'b1;
    end

    // counters idle at zero and restart on every state entry
    tick_d = tick_q;
    ms_d   = ms_q;
    if (enter || !(state_q inside {PLAY, GAP})) begin
      tick_d = '0;
      ms_d   = '0;
    end else if (tick_q == TICK_LAST) begin
      tick_d = '0;
      ms_d   = ms_q + 16'd1;
    end else begin
      tick_d = tick_q + TICK_W'(1);
    end

    freq_d = (state_d == PLAY) ? {16'd0, note_lookup(note_d).hz} : 32'd0;
    busy_d = (state_d == PLAY) || (state_d == GAP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      note_q  <= 3'd0;
      tick_q  <= '0;
      ms_q    <= 16'd0;
      freq_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      tick_q  <= tick_d;
      ms_q    <= ms_d;
      freq_q  <= freq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.freq     = freq_q;
  assign bus.note_idx = note_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player at CLK_FREQ=4000 (4 ticks/ms), GAP_MS=2: vector table, full-song sequence, random run vs timeline model.
// Define MELODY_LOOP_EN for both bench and RTL to exercise the looping build.
module tb_melody_player;

  localparam int T    = 4;
  localparam int GAPT = 2 * T;
  localparam int SONG = 2500 * T + 8 * GAPT;
  localparam int NOTE_HZ [8] = '{262, 294, 330, 349, 392, 0, 392, 262};
  localparam int NOTE_MS [8] = '{250, 250, 250, 250, 500, 250, 250, 500};

  logic clk;
  logic rst;
  melody_player_if bus ();

  melody_player #(.CLK_FREQ(4000), .GAP_MS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // timeline model: mode 0 idle, 1 playing since edge m_t0, 2 end-of-song pulse
  int edge_k = 0;
  int m_mode = 0;
  int m_t0   = 0;
  int m_note = 0;
  int m_freq = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void sched(input int e_in, output int f, output int n);
    int  e;
    bit  found;
    e     = e_in;
    found = 1'b0;
    f     = 0;
    n     = 7;
    for (int i = 0; i < 8; i++) begin
      if (!found) begin
        if (e < NOTE_MS[i] * T) begin
          f = NOTE_HZ[i]; n = i; found = 1'b1;
        end else begin
          e -= NOTE_MS[i] * T;
          if (e < GAPT) begin
            f = 0; n = i; found = 1'b1;
          end else begin
            e -= GAPT;
          end
        end
      end
    end
  endfunction

  task automatic model_edge(input bit s, input bit p, input bit r);
    int e, f, n;
    if (r) begin
      m_mode = 0; m_note = 0;
    end else if (p) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (s) begin m_mode = 1; m_t0 = edge_k; end
    end else if (m_mode == 2) begin
      m_mode = 0;
    end
    m_freq = 0; m_busy = 1'b0; m_done = 1'b0;
    if (m_mode == 1) begin
      e = edge_k - m_t0;
`ifdef MELODY_LOOP_EN
      e = e % SONG;
`else
      if (e == SONG) begin m_mode = 2; m_done = 1'b1; end
`endif
      if (m_mode == 1) begin
        sched(e, f, n);
        m_freq = f; m_note = n; m_busy = 1'b1;
      end
    end
    edge_k++;
  endtask

  task automatic step(input bit s, input bit p, input bit r);
    bus.start = s;
    bus.stop  = p;
    rst       = r;
    @(posedge clk);
    model_edge(s, p, r);
    #1;
  endtask

  typedef struct {
    int          n;
    bit          s, p, r;
    logic [31:0] f;
    logic [2:0]  ni;
    bit          b, d;
  } vec_t;

  vec_t vt [16];

  int busy_cnt, last_busy, done_cnt, done_at;
  bit rs, rp, rr;

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst       = 1'b1;

    //          n    s  p  r   freq  idx b  d
    vt[0]  = '{1,   1, 0, 1,  0,    0,  0, 0};
    vt[1]  = '{1,   1, 0, 1,  0,    0,  0, 0};
    vt[2]  = '{1,   1, 0, 1,  0,    0,  0, 0};
    vt[3]  = '{1,   1, 1, 0,  0,    0,  0, 0};
    vt[4]  = '{3,   0, 0, 0,  0,    0,  0, 0};
    vt[5]  = '{1,   1, 0, 0,  262,  0,  1, 0};
    vt[6]  = '{498, 0, 0, 0,  262,  0,  1, 0};
    vt[7]  = '{1,   1, 0, 0,  262,  0,  1, 0};
    vt[8]  = '{1,   1, 0, 0,  262,  0,  1, 0};
    vt[9]  = '{499, 0, 0, 0,  262,  0,  1, 0};
    vt[10] = '{1,   0, 0, 0,  0,    0,  1, 0};
    vt[11] = '{7,   0, 0, 0,  0,    0,  1, 0};
    vt[12] = '{1,   0, 0, 0,  294,  1,  1, 0};
    vt[13] = '{491, 0, 0, 0,  294,  1,  1, 0};
    vt[14] = '{1,   0, 1, 0,  0,    1,  0, 0};
    vt[15] = '{20,  0, 0, 0,  0,    1,  0, 0};

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < vt[i].n; k++) step(vt[i].s, vt[i].p, vt[i].r);
      chk($sformatf("vec%0d.freq", i), bus.freq, vt[i].f);
      chk($sformatf("vec%0d.note_idx", i), 32'(bus.note_idx), 32'(vt[i].ni));
      chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vt[i].b));
      chk($sformatf("vec%0d.done", i), 32'(bus.done), 32'(vt[i].d));
    end

    // full song from a single start pulse; cycle c is the period after the c-th edge
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 0, 0);
    chk("song.c1.freq", bus.freq, 32'd262);
    busy_cnt  = bus.busy ? 1 : 0;
    last_busy = 1;
    done_cnt  = 0;
    done_at   = -1;
    for (int c = 2; c <= 10070; c++) begin
      step(0, 0, 0);
      if (bus.busy) begin busy_cnt++; last_busy = c; end
      if (bus.done) begin done_cnt++; done_at = c; end
      if (c == 6100) begin
        chk("song.rest.freq", bus.freq, 32'd0);
        chk("song.rest.busy", 32'(bus.busy), 32'd1);
        chk("song.rest.note_idx", 32'(bus.note_idx), 32'd5);
      end
`ifdef MELODY_LOOP_EN
      if (c == 10065) begin
        chk("loop.c10065.freq", bus.freq, 32'd262);
        chk("loop.c10065.note_idx", 32'(bus.note_idx), 32'd0);
        chk("loop.c10065.busy", 32'(bus.busy), 32'd1);
      end
`else
      if (c == 10066) begin
        chk("song.c10066.freq", bus.freq, 32'd0);
        chk("song.c10066.busy", 32'(bus.busy), 32'd0);
        chk("song.c10066.note_idx", 32'(bus.note_idx), 32'd7);
      end
`endif
    end
`ifdef MELODY_LOOP_EN
    chk("loop.busy_cycles", busy_cnt, 32'd10070);
    chk("loop.done_pulses", done_cnt, 32'd0);
`else
    chk("song.busy_cycles", busy_cnt, 32'd10064);
    chk("song.last_busy", last_busy, 32'd10064);
    chk("song.done_pulses", done_cnt, 32'd1);
    chk("song.done_cycle", done_at, 32'd10065);
`endif

    // random start/stop/reset traffic checked every cycle against the timeline model
    step(0, 0, 1);
    for (int c = 0; c < 30000; c++) begin
      rr = ($urandom_range(0, 19999) == 0);
      rp = ($urandom_range(0, 14999) == 0);
      rs = ($urandom_range(0, 63) == 0);
      step(rs, rp, rr);
      chk($sformatf("rand@%0d.freq", c), bus.freq, 32'(m_freq));
      chk($sformatf("rand@%0d.note_idx", c), 32'(bus.note_idx), 32'(m_note));
      chk($sformatf("rand@%0d.busy", c), 32'(bus.busy), 32'(m_busy));
      chk($sformatf("rand@%0d.done", c), 32'(bus.done), 32'(m_done));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/melody_player.md
# melody_player

Tone sequencer that drives the `freq` input of the buzzer square-wave generator. On `start` it steps through a fixed 8-entry note table and presents each note's frequency in Hz on `freq` for that note's duration in milliseconds. Each note is followed by a short silent gap for articulation. It sits between the user-control logic (buttons/FSM) and the square-wave stage, and owns all note timing; the downstream stage only converts Hz to a toggle.

## Interface
- `CLK_FREQ`, default 50000000: clock frequency in Hz. `TICKS_PER_MS = CLK_FREQ/1000` (integer division), must be ≥1.
- `GAP_MS`, default 20: silent gap after every note, in ms. 0 means no gap.
- `clk` input 1: system clock. Single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level sampled each cycle; begins playback from note 0 when idle.
- `stop` input 1: aborts playback; stop wins over a simultaneous start.
- `freq` output 32: note frequency in Hz, 0 means silence. Feeds the square-wave stage directly.
- `note_idx` output 3: index of the current or most recent note.
- `busy` output 1: high while playing or in a gap.
- `done` output 1: one-cycle pulse at natural end of song.

## Operation
- Note table is fixed, indexed as {Hz, ms}:
  - 0: {262, 250}
  - 1: {294, 250}
  - 2: {330, 250}
  - 3: {349, 250}
  - 4: {392, 500}
  - 5: {0, 250}, a rest
  - 6: {392, 250}
  - 7: {262, 500}
- States:
  - IDLE
  - PLAY
  - GAP
  - DONE
- IDLE: `freq=0`, `busy=0`. `start=1` and `stop=0` go to PLAY with `note_idx=0`.
- PLAY: `freq` = table Hz of `note_idx`. The state lasts exactly `dur_ms*TICKS_PER_MS` cycles.
  - Then go to GAP if `GAP_MS>0`.
  - Otherwise advance directly.
- GAP: `freq=0` for exactly `GAP_MS*TICKS_PER_MS` cycles, then advance.
- Advance:
  - If `note_idx<7`, increment and go to PLAY.
  - If `note_idx==7`, go to DONE, which is the end-of-song case.
- DONE: lasts one cycle with `done=1`, `busy=0`, `freq=0`, then goes to IDLE.
- `stop=1` in any state: next state IDLE. `freq=0`, `busy=0`, no `done` pulse. `note_idx` is held.
- `start` while busy is ignored; it does not restart.
- Timing counters:
  - `tick_cnt` counts 0..`TICKS_PER_MS-1`.
  - `ms_cnt` is 16 bits and counts elapsed ms in the current PLAY/GAP.
  - Both clear on every state entry.
- A rest entry (Hz 0) is timed exactly like a note; `busy` stays 1.

## Timing
- All outputs are registered.
- Reset values: `freq=0`, `note_idx=0`, `busy=0`, `done=0`, state IDLE, counters 0.
- Reset asserted mid-song: next cycle all outputs take their reset values.
- Start latency: `start` is sampled high at edge N. From edge N+1, `freq`=262 and `busy=1`.
- Note 0 occupies cycles N+1 .. N+`250*TICKS_PER_MS`.
- Stop latency: `stop` is sampled at edge N. At N+1, `freq=0` and `busy=0`.
- Song length: 2500 ms of notes plus `8*GAP_MS` of gaps.
  - `done` is high in the single cycle after the last gap cycle.

## Configuration
- Macro `MELODY_LOOP_EN`.
- Defined: after note 7 (and its gap) the block returns to PLAY at note 0. DONE is never entered and `done` stays 0. Playback runs until `stop` or `rst`.
- Undefined: the song plays once, then DONE, then IDLE, as described above.

## Test plan
All scenarios use `CLK_FREQ=4000` (`TICKS_PER_MS=4`) and `GAP_MS=2`, with the macro undefined unless stated.
1. Reset: hold `rst` for 3 cycles with `start=1` → `freq=0`, `busy=0`, `done=0`, `note_idx=0` throughout.
2. Start pulse at edge 0:
   - `freq=262` for cycles 1–1000.
   - `freq=0` for cycles 1001–1008.
   - `freq=294` with `note_idx=1` at cycle 1009.
3. Full song from edge 0:
   - Note 5 shows `freq=0` with `busy=1`.
   - `busy` is high for cycles 1–10064.
   - `done`=1 only at cycle 10065; IDLE from 10066.
4. `stop` at cycle 1500, during note 1 → cycle 1501 `freq=0`, `busy=0`, `note_idx=1`, and no `done` pulse ever.
5. Corner cases:
   - `start` and `stop` both high while idle → remains IDLE.
   - `start` re-asserted at cycle 500 while playing → note 0 timing unchanged, still ends at cycle 1000.
6. `MELODY_LOOP_EN` defined:
   - After the last gap, cycle 10065 shows `freq=262`, `note_idx=0`, `busy=1`.
   - `done` never asserts.
